// File: rtl/serial_compare_sequencer.sv
// Bit-serial magnitude comparator: one L/G/E cell stepped MSB-first, with early exit
// at the first differing bit and optional IEEE-754 sign-magnitude ordering.
module serial_compare_sequencer #(
    parameter int WIDTH   = 32,
    parameter bit FP_MODE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       lt,
    output logic                       gt,
    output logic                       eq,
    output logic [$clog2(WIDTH+1)-1:0] steps,
    output logic                       busy
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [SW-1:0]    steps_reg, steps_next;
    logic             l_reg, l_next;
    logic             g_reg, g_next;
    logic             e_reg, e_next;
    logic             swap_reg, swap_next;

    // Single 1-bit comparator cell, chained through the registered L/G/E.
    logic a_bit, b_bit, l_cell, g_cell, e_cell;
    assign a_bit  = a_reg[idx_reg];
    assign b_bit  = b_reg[idx_reg];
    assign l_cell = (~a_bit & b_bit & e_reg) | l_reg;
    assign g_cell = (a_bit & ~b_bit & e_reg) | g_reg;
    assign e_cell = ~(a_bit ^ b_bit) & e_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            steps_reg <= '0;
            l_reg     <= 1'b0;
            g_reg     <= 1'b0;
            e_reg     <= 1'b1;
            swap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            steps_reg <= steps_next;
            l_reg     <= l_next;
            g_reg     <= g_next;
            e_reg     <= e_next;
            swap_reg  <= swap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        steps_next = steps_reg;
        l_next     = l_reg;
        g_next     = g_reg;
        e_next     = e_reg;
        swap_next  = swap_reg;
        in_ready   = (state_reg == IDLE);
        out_valid  = (state_reg == DONE);
        busy       = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    l_next     = 1'b0;
                    g_next     = 1'b0;
                    e_next     = 1'b1;
                    steps_next = '0;
                    swap_next  = 1'b0;
                    if (!FP_MODE) begin
                        idx_next   = IW'(WIDTH-1);
                        state_next = SCAN;
                    end else if ((a[WIDTH-2:0] == '0) && (b[WIDTH-2:0] == '0)) begin
                        // +0 and -0 order as equal regardless of sign bits
                        state_next = DONE;
                    end else if (a[WIDTH-1] != b[WIDTH-1]) begin
                        l_next     = a[WIDTH-1];
                        g_next     = ~a[WIDTH-1];
                        e_next     = 1'b0;
                        state_next = DONE;
                    end else begin
                        // Both negative: larger magnitude is the smaller value
                        idx_next   = IW'(WIDTH-2);
                        swap_next  = a[WIDTH-1];
                        state_next = SCAN;
                    end
                end
            end
            SCAN: begin
                l_next     = l_cell;
                g_next     = g_cell;
                e_next     = e_cell;
                steps_next = steps_reg + SW'(1);
                if (l_cell || g_cell || (idx_reg == '0)) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign lt    = (state_reg == DONE) & (swap_reg ? g_reg : l_reg);
    assign gt    = (state_reg == DONE) & (swap_reg ? l_reg : g_reg);
    assign eq    = (state_reg == DONE) & e_reg;
    assign steps = steps_reg;

endmodule
